// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between instruction fetch and data access.
// Latency: store ack 2 cycles after req, load/fetch ack LATENCY+2 cycles.
// Backpressure: requests hold until ack; a loser waits in place, starve_cnt bounds data priority.
//
// Ports:
//   clock, reset                  - single clock, async active-low reset
//   if_req/if_addr/if_flush       - fetch request, PC, cancel of outstanding fetch
//   if_ack/if_rdata               - fetch completion pulse and instruction
//   dm_req/dm_wr/dm_addr/dm_wdata - data request, store flag, address, store data
//   dm_ack/dm_rdata               - data completion pulse and load data
//   mem_addr/mem_wdata/mem_wr     - shared memory request (all registered)
//   mem_rdata                     - shared memory read data, valid LATENCY cycles after issue
//   busy                          - high whenever the FSM is not IDLE
module mem_arbiter #(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_wr,
  input  logic [63:0] dm_addr,
  input  logic [63:0] dm_wdata,
  output logic        dm_ack,
  output logic [63:0] dm_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata,
  output logic        busy
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic          gnt_dm, gnt_dm_n;     // 1: current access belongs to the data port
  logic          flushed, flushed_n;   // current fetch was cancelled
  logic [2:0]    wait_cnt, wait_cnt_n;
  logic [SW-1:0] starve_cnt, starve_cnt_n;

  logic          if_ack_n, dm_ack_n, mem_wr_n, busy_n;
  logic [31:0]   if_rdata_n;
  logic [63:0]   dm_rdata_n, mem_addr_n, mem_wdata_n;

  logic          mask_dm, mask_if, dm_ok, if_ok, pick_dm, pick_if;

  always_comb begin
    state_n      = state;
    gnt_dm_n     = gnt_dm;
    flushed_n    = flushed;
    wait_cnt_n   = wait_cnt;
    starve_cnt_n = starve_cnt;
    if_ack_n     = 1'b0;
    dm_ack_n     = 1'b0;
    mem_wr_n     = 1'b0;
    if_rdata_n   = if_rdata;
    dm_rdata_n   = dm_rdata;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;

    // In RESP the requester being acked still shows the old req level, so it
    // is excluded. A cancelled fetch was never acked and may be granted again.
    mask_dm = (state == RESP) && gnt_dm;
    mask_if = (state == RESP) && !gnt_dm && !flushed;
    dm_ok   = dm_req && !mask_dm;
    if_ok   = if_req && !mask_if;
    pick_dm = dm_ok && !(if_ok && (starve_cnt == SW'(STARVE_MAX)));
    pick_if = if_ok && !pick_dm;

    case (state)
      ISSUE: begin
        if (!gnt_dm && if_flush) flushed_n = 1'b1;
        // mem_wr is only ever set for a data store, so it doubles as the store flag
        if (mem_wr) begin
          state_n  = RESP;
          dm_ack_n = 1'b1;
        end else begin
          state_n    = WAIT;
          wait_cnt_n = 3'(LATENCY);
        end
      end
      WAIT: begin
        if (!gnt_dm && if_flush) flushed_n = 1'b1;
        if (wait_cnt == 3'd1) begin
          state_n    = RESP;
          wait_cnt_n = 3'd0;
          if (gnt_dm) begin
            dm_ack_n   = 1'b1;
            dm_rdata_n = mem_rdata;
          end else if (!(flushed || if_flush)) begin
            if_ack_n   = 1'b1;
            if_rdata_n = mem_rdata[31:0];
          end
        end else begin
          wait_cnt_n = wait_cnt - 3'd1;
        end
      end
      default: begin  // IDLE and RESP both arbitrate
        state_n = IDLE;
        if (pick_dm || pick_if) begin
          state_n    = ISSUE;
          gnt_dm_n   = pick_dm;
          flushed_n  = 1'b0;
          mem_addr_n = pick_dm ? dm_addr : {32'b0, if_addr};
          if (pick_dm) mem_wdata_n = dm_wdata;
          mem_wr_n   = pick_dm && dm_wr;
          if (pick_if)
            starve_cnt_n = '0;
          else if (if_req && (starve_cnt != SW'(STARVE_MAX)))
            starve_cnt_n = starve_cnt + 1'b1;
        end
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      gnt_dm     <= 1'b0;
      flushed    <= 1'b0;
      wait_cnt   <= '0;
      starve_cnt <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      mem_wr     <= 1'b0;
      busy       <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      gnt_dm     <= gnt_dm_n;
      flushed    <= flushed_n;
      wait_cnt   <= wait_cnt_n;
      starve_cnt <= starve_cnt_n;
      if_ack     <= if_ack_n;
      dm_ack     <= dm_ack_n;
      mem_wr     <= mem_wr_n;
      busy       <= busy_n;
      if_rdata   <= if_rdata_n;
      dm_rdata   <= dm_rdata_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: random fetch/data traffic against a transaction-timed reference model.
// Latency: model predicts ack edges from grant edge plus access duration.
// Backpressure: bench agents hold req until ack, then optionally re-request at once.
module tb_mem_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_wr, dm_ack;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, busy;

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents as a pure function of the byte address.
  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, a[31:0] + 32'h1234_5678};
  endfunction

  // ---------------- reference model: one record per access ----------------
  int          cyc;                 // number of rising edges seen
  bit          act;                 // an access occupies the port
  int          g_edge, ack_edge;    // grant edge, edge on which the ack appears
  bit          t_d, t_wr, t_fl;
  logic [63:0] t_addr;
  int          starve;
  logic        e_if_ack, e_dm_ack, e_mem_wr, e_busy;
  logic [31:0] e_if_rdata;
  logic [63:0] e_dm_rdata, e_mem_addr, e_mem_wdata;
  logic        s_if_ack, s_dm_ack;

  task automatic model_reset();
    act = 0; g_edge = -10; ack_edge = -10; t_d = 0; t_wr = 0; t_fl = 0; t_addr = '0;
    starve = 0;
    e_if_ack = 0; e_dm_ack = 0; e_mem_wr = 0; e_busy = 0;
    e_if_rdata = '0; e_dm_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
    s_if_ack = 0; s_dm_ack = 0;
  endtask

  // Predict outputs after edge e from the inputs currently applied.
  task automatic model_step(input int e);
    logic [63:0] v;
    bit arb, ex_d, ex_f, d_ok, f_ok, gd;
    e_if_ack = 0; e_dm_ack = 0; e_mem_wr = 0;
    arb = !act || (e == ack_edge + 1);
    if (act && !t_d && e > g_edge && e <= ack_edge && if_flush) t_fl = 1;
    if (act && e == ack_edge) begin
      v = mem_fn(t_addr);
      if (t_d) begin
        e_dm_ack = 1;
        if (!t_wr) e_dm_rdata = v;
      end else if (!t_fl) begin
        e_if_ack   = 1;
        e_if_rdata = v[31:0];
      end
    end
    if (arb) begin
      ex_d = act && t_d;
      ex_f = act && !t_d && !t_fl;
      d_ok = dm_req && !ex_d;
      f_ok = if_req && !ex_f;
      act  = 0;
      if (d_ok || f_ok) begin
        gd       = d_ok && !(f_ok && starve == SMAX);
        act      = 1;
        g_edge   = e;
        t_d      = gd;
        t_wr     = gd && dm_wr;
        t_fl     = 0;
        t_addr   = gd ? dm_addr : {32'b0, if_addr};
        ack_edge = e + (t_wr ? 1 : LAT + 1);
        if (gd) begin
          e_mem_wdata = dm_wdata;
          if (if_req && starve < SMAX) starve++;
        end else begin
          starve = 0;
        end
        e_mem_addr = t_addr;
        e_mem_wr   = t_wr;
      end
    end
    e_busy = act;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_if_ack"},    64'(if_ack),    64'd0);
    check({tag, "_dm_ack"},    64'(dm_ack),    64'd0);
    check({tag, "_mem_wr"},    64'(mem_wr),    64'd0);
    check({tag, "_busy"},      64'(busy),      64'd0);
    check({tag, "_if_rdata"},  64'(if_rdata),  64'd0);
    check({tag, "_dm_rdata"},  dm_rdata,       64'd0);
    check({tag, "_mem_addr"},  mem_addr,       64'd0);
    check({tag, "_mem_wdata"}, mem_wdata,      64'd0);
  endtask

  // Requester agents: hold until ack, then drop or issue a new request at once.
  task automatic drive_agents();
    bit nd, nf;
    nd = 0; nf = 0;
    if (dm_req && s_dm_ack) begin
      dm_req = 1'($urandom % 2); nd = dm_req;
    end else if (!dm_req) begin
      dm_req = ($urandom % 3 == 0); nd = dm_req;
    end else if (act && t_d) begin
      // request already latched: scrambling the inputs must not matter
      dm_wr = 1'($urandom % 2); dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
    end
    if (nd) begin
      dm_wr = 1'($urandom % 2); dm_addr = {$urandom, $urandom}; dm_wdata = {$urandom, $urandom};
    end
    if (if_req && s_if_ack) begin
      if_req = 1'($urandom % 2); nf = if_req;
    end else if (!if_req) begin
      if_req = ($urandom % 3 == 0); nf = if_req;
    end
    if (nf || (act && !t_d)) if_addr = $urandom & 32'hFFFF_FFFC;
    // a registered ack cannot be withdrawn in its own cycle, so no flush in fetch RESP
    if_flush = ($urandom % 10 == 0) && !(act && !t_d && cyc == ack_edge);
  endtask

  task automatic one_cycle(input bit rnd);
    @(negedge clock);
    check("if_ack",   64'(if_ack),   64'(e_if_ack));
    check("dm_ack",   64'(dm_ack),   64'(e_dm_ack));
    check("mem_wr",   64'(mem_wr),   64'(e_mem_wr));
    check("busy",     64'(busy),     64'(e_busy));
    check("if_rdata", 64'(if_rdata), 64'(e_if_rdata));
    check("dm_rdata", dm_rdata,      e_dm_rdata);
    if (act && cyc == g_edge) begin
      check("mem_addr", mem_addr, e_mem_addr);
      if (t_wr) check("mem_wdata", mem_wdata, e_mem_wdata);
    end
    s_if_ack = if_ack;
    s_dm_ack = dm_ack;
    model_step(cyc + 1);
    @(posedge clock);
    cyc++;
    #1;
    if (rnd) drive_agents();
    // read data valid only in the cycle LATENCY edges after the grant edge
    if (act && !t_wr && cyc == ack_edge - 1) mem_rdata = mem_fn(t_addr);
    else                                      mem_rdata = {$urandom, $urandom};
  endtask

  initial begin
    cyc = 0;
    reset = 1'b0;
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_req = 0; dm_wr = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    model_reset();
    #1;
    check_zero("rst");
    repeat (2) begin @(posedge clock); cyc++; end
    #1 reset = 1'b1;

    repeat (1500) one_cycle(1'b1);

    // drain, then reset in the middle of a load's WAIT phase
    dm_req = 0; if_req = 0; if_flush = 0;
    repeat (LAT + 6) one_cycle(1'b0);
    dm_req = 1; dm_wr = 0; dm_addr = 64'h100; dm_wdata = 64'h0;
    one_cycle(1'b0);
    one_cycle(1'b0);
    check("wait_busy", 64'(busy), 64'(e_busy));
    #2 reset = 1'b0;
    #1;
    check_zero("mid_rst");
    model_reset();
    dm_req = 0;
    repeat (2) begin @(posedge clock); cyc++; end
    #1 reset = 1'b1;
    repeat (LAT + 4) one_cycle(1'b0);

    repeat (600) one_cycle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
